register_file_mp: RTL and testbench

Parametrised successor to the stage-5 integer register file. It has a configurable data width, register count, and number of read and write ports, with register 0 optionally hardwired to zero. Write-to-read bypass is optional. A pending-write scoreboard tracks registers with an in-flight producer. It sits in stage 5 (register read) and is written from the writeback stage; the issue logic sets the pending bits.

---
 rtl/register_file_mp_if.sv | 29 ++
 rtl/register_file_mp.sv | 108 ++++++++++
 tb/tb_register_file_mp.sv | 314 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/register_file_mp_if.sv
// Register-file bus: read ports, writeback ports and the issue-side pending-set request.
// The issuing/writeback side is the master; the register file is the slave.
interface register_file_mp_if #(
  parameter int DATA_WIDTH  = 32,
  parameter int NUM_REGS    = 32,
  parameter int READ_PORTS  = 2,
  parameter int WRITE_PORTS = 1
);
  localparam int TAG_WIDTH = $clog2(NUM_REGS);

  logic [READ_PORTS*TAG_WIDTH-1:0]   rs_addr;
  logic [READ_PORTS*DATA_WIDTH-1:0]  rs_data;
  logic [READ_PORTS-1:0]             rs_busy;
  logic [WRITE_PORTS-1:0]            wr_en;
  logic [WRITE_PORTS*TAG_WIDTH-1:0]  wr_addr;
  logic [WRITE_PORTS*DATA_WIDTH-1:0] wr_data;
  logic                              issue_en;
  logic [TAG_WIDTH-1:0]              issue_rd;

  modport master (
    output rs_addr, wr_en, wr_addr, wr_data, issue_en, issue_rd,
    input  rs_data, rs_busy
  );

  modport slave (
    input  rs_addr, wr_en, wr_addr, wr_data, issue_en, issue_rd,
    output rs_data, rs_busy
  );
endinterface

// File: rtl/register_file_mp.sv
// Multi-ported stage-5 integer register file with optional write-to-read bypass,
// optional hardwired zero register and a per-register pending-write scoreboard.
module register_file_mp #(
  parameter int DATA_WIDTH  = 32,
  parameter int NUM_REGS    = 32,
  parameter int READ_PORTS  = 2,
  parameter int WRITE_PORTS = 1,
  parameter int BYPASS      = 1,
  parameter int ZERO_REG    = 1
) (
  input  logic                clock,
  input  logic                reset_n,
  register_file_mp_if.slave   rf
);
  localparam int TAG_WIDTH = $clog2(NUM_REGS);

  logic [DATA_WIDTH-1:0]             regs_r [NUM_REGS];
  logic [NUM_REGS-1:0]               pending_r;
  logic [READ_PORTS*DATA_WIDTH-1:0]  rs_data_r;
  logic [READ_PORTS-1:0]             rs_busy_r;

  logic [NUM_REGS-1:0]               wr_hit_s;
  logic [DATA_WIDTH-1:0]             wr_val_s [NUM_REGS];
  logic [NUM_REGS-1:0]               pending_nxt_s;
  logic [TAG_WIDTH-1:0]              rd_idx_s [READ_PORTS];
  logic [READ_PORTS*DATA_WIDTH-1:0]  rd_data_s;
  logic [READ_PORTS-1:0]             rd_busy_s;

  function automatic logic is_zero_idx(input logic [TAG_WIDTH-1:0] idx);
    return (ZERO_REG != 0) && (idx == {TAG_WIDTH{1'b0}});
  endfunction

  // Resolve writeback ports per register; scanning upward lets the highest port win.
  always_comb begin
    wr_hit_s = {NUM_REGS{1'b0}};
    for (int r = 0; r < NUM_REGS; r++) begin
      wr_val_s[r] = {DATA_WIDTH{1'b0}};
      for (int w = 0; w < WRITE_PORTS; w++) begin
        logic hit;
        hit = rf.wr_en[w]
              && (rf.wr_addr[w*TAG_WIDTH +: TAG_WIDTH] == TAG_WIDTH'(r))
              && !is_zero_idx(TAG_WIDTH'(r));
        wr_hit_s[r] = wr_hit_s[r] | hit;
        wr_val_s[r] = hit ? rf.wr_data[w*DATA_WIDTH +: DATA_WIDTH] : wr_val_s[r];
      end
    end
  end

  // Scoreboard next state: a new producer supersedes a completing one.
  always_comb begin
    pending_nxt_s = {NUM_REGS{1'b0}};
    for (int r = 0; r < NUM_REGS; r++) begin
      if (rf.issue_en && (rf.issue_rd == TAG_WIDTH'(r)) && !is_zero_idx(TAG_WIDTH'(r))) begin
        pending_nxt_s[r] = 1'b1;
      end else if (wr_hit_s[r]) begin
        pending_nxt_s[r] = 1'b0;
      end else begin
        pending_nxt_s[r] = pending_r[r];
      end
    end
  end

  // Slice the packed read-index bus into one index per port.
  always_comb begin
    for (int p = 0; p < READ_PORTS; p++) begin
      rd_idx_s[p] = rf.rs_addr[p*TAG_WIDTH +: TAG_WIDTH];
    end
  end

  // Read mux; register 0 never holds a nonzero value or a pending bit when hardwired.
  always_comb begin
    rd_data_s = {(READ_PORTS*DATA_WIDTH){1'b0}};
    rd_busy_s = {READ_PORTS{1'b0}};
    for (int p = 0; p < READ_PORTS; p++) begin
      if (BYPASS != 0) begin
        rd_data_s[p*DATA_WIDTH +: DATA_WIDTH] =
          wr_hit_s[rd_idx_s[p]] ? wr_val_s[rd_idx_s[p]] : regs_r[rd_idx_s[p]];
        rd_busy_s[p] = pending_nxt_s[rd_idx_s[p]];
      end else begin
        rd_data_s[p*DATA_WIDTH +: DATA_WIDTH] = regs_r[rd_idx_s[p]];
        rd_busy_s[p] = pending_r[rd_idx_s[p]];
      end
    end
  end

  // Architectural state, scoreboard and registered read outputs.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int r = 0; r < NUM_REGS; r++) begin
        regs_r[r] <= {DATA_WIDTH{1'b0}};
      end
      pending_r <= {NUM_REGS{1'b0}};
      rs_data_r <= {(READ_PORTS*DATA_WIDTH){1'b0}};
      rs_busy_r <= {READ_PORTS{1'b0}};
    end else begin
      for (int r = 0; r < NUM_REGS; r++) begin
        regs_r[r] <= wr_hit_s[r] ? wr_val_s[r] : regs_r[r];
      end
      pending_r <= pending_nxt_s;
      rs_data_r <= rd_data_s;
      rs_busy_r <= rd_busy_s;
    end
  end

  assign rf.rs_data = rs_data_r;
  assign rf.rs_busy = rs_busy_r;

endmodule

// File: tb/tb_register_file_mp.sv
// Scoreboard bench: directed vectors on bypass / no-bypass instances plus a modelled
// random soak on a 64-bit, 16-register, 3-read / 2-write instance.
module tb_register_file_mp;

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  logic reset_c_n = 1'b0;
  always #5 clock = ~clock;

  // Shared stimulus for the two 32-bit instances (A: bypass, B: no bypass)
  logic [9:0]  rs_addr_ab;
  logic [1:0]  wr_en_ab;
  logic [9:0]  wr_addr_ab;
  logic [63:0] wr_data_ab;
  logic        issue_en_ab;
  logic [4:0]  issue_rd_ab;

  // Soak instance stimulus
  logic [11:0]  rs_addr_c;
  logic [1:0]   wr_en_c;
  logic [7:0]   wr_addr_c;
  logic [127:0] wr_data_c;
  logic         issue_en_c;
  logic [3:0]   issue_rd_c;

  register_file_mp_if #(.DATA_WIDTH(32), .NUM_REGS(32), .READ_PORTS(2), .WRITE_PORTS(2)) bus_a ();
  register_file_mp_if #(.DATA_WIDTH(32), .NUM_REGS(32), .READ_PORTS(2), .WRITE_PORTS(2)) bus_b ();
  register_file_mp_if #(.DATA_WIDTH(64), .NUM_REGS(16), .READ_PORTS(3), .WRITE_PORTS(2)) bus_c ();

  assign bus_a.rs_addr  = rs_addr_ab;
  assign bus_a.wr_en    = wr_en_ab;
  assign bus_a.wr_addr  = wr_addr_ab;
  assign bus_a.wr_data  = wr_data_ab;
  assign bus_a.issue_en = issue_en_ab;
  assign bus_a.issue_rd = issue_rd_ab;
  assign bus_b.rs_addr  = rs_addr_ab;
  assign bus_b.wr_en    = wr_en_ab;
  assign bus_b.wr_addr  = wr_addr_ab;
  assign bus_b.wr_data  = wr_data_ab;
  assign bus_b.issue_en = issue_en_ab;
  assign bus_b.issue_rd = issue_rd_ab;
  assign bus_c.rs_addr  = rs_addr_c;
  assign bus_c.wr_en    = wr_en_c;
  assign bus_c.wr_addr  = wr_addr_c;
  assign bus_c.wr_data  = wr_data_c;
  assign bus_c.issue_en = issue_en_c;
  assign bus_c.issue_rd = issue_rd_c;

  register_file_mp #(.DATA_WIDTH(32), .NUM_REGS(32), .READ_PORTS(2), .WRITE_PORTS(2),
                     .BYPASS(1), .ZERO_REG(1))
    dut_a (.clock(clock), .reset_n(reset_n), .rf(bus_a));
  register_file_mp #(.DATA_WIDTH(32), .NUM_REGS(32), .READ_PORTS(2), .WRITE_PORTS(2),
                     .BYPASS(0), .ZERO_REG(1))
    dut_b (.clock(clock), .reset_n(reset_n), .rf(bus_b));
  register_file_mp #(.DATA_WIDTH(64), .NUM_REGS(16), .READ_PORTS(3), .WRITE_PORTS(2),
                     .BYPASS(1), .ZERO_REG(1))
    dut_c (.clock(clock), .reset_n(reset_c_n), .rf(bus_c));

  typedef struct {
    int          dut;
    int          port;
    int          edge_no;
    logic [63:0] data;
    logic        busy;
    string       name;
  } exp_t;

  exp_t exp_q[$];
  int   edge_cnt = 0;
  int   pass_cnt = 0;
  int   total_cnt = 0;

  exp_t        mon_e;
  logic [63:0] mon_d;
  logic        mon_b;

  // Monitor: every read output is valid #1 after the edge; pop and compare what is due.
  always @(posedge clock) begin
    edge_cnt = edge_cnt + 1;
    #1;
    while (exp_q.size() > 0 && exp_q[0].edge_no <= edge_cnt) begin
      mon_e = exp_q.pop_front();
      case (mon_e.dut)
        0: begin
          mon_d = {32'h0, bus_a.rs_data[mon_e.port*32 +: 32]};
          mon_b = bus_a.rs_busy[mon_e.port];
        end
        1: begin
          mon_d = {32'h0, bus_b.rs_data[mon_e.port*32 +: 32]};
          mon_b = bus_b.rs_busy[mon_e.port];
        end
        default: begin
          mon_d = bus_c.rs_data[mon_e.port*64 +: 64];
          mon_b = bus_c.rs_busy[mon_e.port];
        end
      endcase
      total_cnt = total_cnt + 1;
      if (mon_d === mon_e.data && mon_b === mon_e.busy) begin
        pass_cnt = pass_cnt + 1;
      end else begin
        $display("FAIL %s dut%0d port%0d edge%0d: got data=%h busy=%b, expected data=%h busy=%b",
                 mon_e.name, mon_e.dut, mon_e.port, edge_cnt, mon_d, mon_b, mon_e.data, mon_e.busy);
      end
    end
  end

  task automatic expect_rd(input int dut, input int port, input logic [63:0] d, input logic b,
                           input string n);
    exp_t e;
    e.dut = dut; e.port = port; e.edge_no = edge_cnt + 1; e.data = d; e.busy = b; e.name = n;
    exp_q.push_back(e);
  endtask

  task automatic expect_ab(input int port, input logic [31:0] d, input logic b, input string n);
    expect_rd(0, port, {32'h0, d}, b, n);
    expect_rd(1, port, {32'h0, d}, b, n);
  endtask

  task automatic check_now(input string n, input logic [63:0] act, input logic [63:0] exp_v);
    total_cnt = total_cnt + 1;
    if (act === exp_v) pass_cnt = pass_cnt + 1;
    else $display("FAIL %s: got %h, expected %h", n, act, exp_v);
  endtask

  task automatic clr();
    rs_addr_ab = 10'h0; wr_en_ab = 2'b00; wr_addr_ab = 10'h0; wr_data_ab = 64'h0;
    issue_en_ab = 1'b0; issue_rd_ab = 5'h0;
  endtask

  task automatic rd(input int p, input int a);
    rs_addr_ab[p*5 +: 5] = 5'(a);
  endtask

  task automatic wr(input int w, input int a, input logic [31:0] d);
    wr_en_ab[w] = 1'b1; wr_addr_ab[w*5 +: 5] = 5'(a); wr_data_ab[w*32 +: 32] = d;
  endtask

  task automatic iss(input int a);
    issue_en_ab = 1'b1; issue_rd_ab = 5'(a);
  endtask

  task automatic step();
    @(negedge clock);
    clr();
  endtask

  // Reference model for the soak instance
  logic [63:0] m_regs [16];
  logic        m_pend [16];
  logic        m_hit  [16];
  logic [63:0] m_val  [16];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    clr();
    rs_addr_c = 12'h0; wr_en_c = 2'b00; wr_addr_c = 8'h0; wr_data_c = 128'h0;
    issue_en_c = 1'b0; issue_rd_c = 4'h0;
    for (int r = 0; r < 16; r++) begin m_regs[r] = 64'h0; m_pend[r] = 1'b0; end
    #1;
    check_now("reset_data_a", {32'h0, bus_a.rs_data}, 64'h0);
    check_now("reset_busy_b", {62'h0, bus_b.rs_busy}, 64'h0);
    @(negedge clock);
    @(negedge clock);
    reset_n = 1'b1;
    reset_c_n = 1'b1;

    // All registers read zero after reset
    for (int i = 1; i < 32; i += 2) begin
      rd(0, i); rd(1, (i + 1) % 32);
      expect_ab(0, 32'h0, 1'b0, "post_reset_p0");
      expect_ab(1, 32'h0, 1'b0, "post_reset_p1");
      step();
    end

    // Basic write / read and hardwired x0
    wr(0, 5, 32'hDEADBEEF); step();
    rd(0, 5); rd(1, 0);
    expect_ab(0, 32'hDEADBEEF, 1'b0, "read_x5");
    expect_ab(1, 32'h0, 1'b0, "read_x0");
    step();
    wr(1, 0, 32'h1234); rd(1, 0);
    expect_ab(1, 32'h0, 1'b0, "x0_write_bypass");
    step();
    rd(0, 0);
    expect_ab(0, 32'h0, 1'b0, "x0_after_write");
    step();

    // Bypass vs. old value
    wr(0, 7, 32'h11); step();
    wr(0, 7, 32'hA5A5A5A5); rd(0, 7);
    expect_rd(0, 0, 64'hA5A5A5A5, 1'b0, "bypass_x7");
    expect_rd(1, 0, 64'h11, 1'b0, "nobypass_x7");
    step();
    rd(0, 7);
    expect_ab(0, 32'hA5A5A5A5, 1'b0, "x7_committed");
    step();

    // Write conflict: highest port wins
    wr(0, 3, 32'h1); wr(1, 3, 32'h2); rd(0, 3);
    expect_rd(0, 0, 64'h2, 1'b0, "conflict_bypass");
    expect_rd(1, 0, 64'h0, 1'b0, "conflict_nobypass");
    step();
    rd(0, 3);
    expect_ab(0, 32'h2, 1'b0, "conflict_commit");
    step();

    // Scoreboard
    iss(9); rd(1, 9);
    expect_rd(0, 1, 64'h0, 1'b1, "issue_busy_bypass");
    expect_rd(1, 1, 64'h0, 1'b0, "issue_busy_nobypass");
    step();
    rd(1, 9);
    expect_ab(1, 32'h0, 1'b1, "pending_x9");
    step();
    wr(0, 9, 32'hCAFE); rd(1, 9);
    expect_rd(0, 1, 64'hCAFE, 1'b0, "wb_forward_clear");
    expect_rd(1, 1, 64'h0, 1'b1, "wb_nobypass_old");
    step();
    rd(1, 9);
    expect_ab(1, 32'hCAFE, 1'b0, "wb_cleared");
    step();
    iss(9); wr(1, 9, 32'hBEEF); rd(0, 9);
    expect_rd(0, 0, 64'hBEEF, 1'b1, "set_wins_bypass");
    expect_rd(1, 0, 64'hCAFE, 1'b0, "set_wins_nobypass");
    step();
    rd(0, 9);
    expect_ab(0, 32'hBEEF, 1'b1, "set_wins_held");
    step();
    iss(0); rd(0, 0);
    expect_ab(0, 32'h0, 1'b0, "issue_x0_ignored");
    step();
    rd(0, 0);
    expect_ab(0, 32'h0, 1'b0, "x0_never_pending");
    step();
    wr(0, 10, 32'h77); rd(0, 9); rd(1, 10);
    expect_ab(0, 32'hBEEF, 1'b1, "other_pending_kept");
    expect_rd(0, 1, 64'h77, 1'b0, "unissued_wr_bypass");
    expect_rd(1, 1, 64'h0, 1'b0, "unissued_wr_nobypass");
    @(negedge clock);

    // Asynchronous reset mid-cycle clears outputs at once
    #2 reset_n = 1'b0;
    #1;
    check_now("async_reset_data_a", {32'h0, bus_a.rs_data}, 64'h0);
    check_now("async_reset_busy_a", {62'h0, bus_a.rs_busy}, 64'h0);
    check_now("async_reset_data_b", {32'h0, bus_b.rs_data}, 64'h0);
    @(negedge clock);
    reset_n = 1'b1;
    clr();
    rd(0, 9); rd(1, 5);
    expect_ab(0, 32'h0, 1'b0, "reset_x9");
    expect_ab(1, 32'h0, 1'b0, "reset_x5");
    step();

    // Random soak against a reference model, with occasional reset pulses
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if ($urandom_range(0, 199) == 0) begin
        reset_c_n = 1'b0;
        for (int r = 0; r < 16; r++) begin m_regs[r] = 64'h0; m_pend[r] = 1'b0; end
        for (int p = 0; p < 3; p++) expect_rd(2, p, 64'h0, 1'b0, "soak_reset");
        @(negedge clock);
        reset_c_n = 1'b1;
      end else begin
        rs_addr_c  = 12'($urandom);
        wr_en_c    = 2'($urandom);
        wr_addr_c  = 8'($urandom);
        wr_data_c  = {$urandom, $urandom, $urandom, $urandom};
        issue_en_c = ($urandom_range(0, 2) == 0);
        issue_rd_c = 4'($urandom);
        for (int r = 0; r < 16; r++) begin m_hit[r] = 1'b0; m_val[r] = 64'h0; end
        for (int w = 0; w < 2; w++) begin
          if (wr_en_c[w] && wr_addr_c[w*4 +: 4] != 4'h0) begin
            m_hit[wr_addr_c[w*4 +: 4]] = 1'b1;
            m_val[wr_addr_c[w*4 +: 4]] = wr_data_c[w*64 +: 64];
          end
        end
        for (int p = 0; p < 3; p++) begin
          logic [3:0]  a;
          logic [63:0] ed;
          logic        eb;
          a = rs_addr_c[p*4 +: 4];
          if (a == 4'h0) begin
            ed = 64'h0; eb = 1'b0;
          end else begin
            ed = m_hit[a] ? m_val[a] : m_regs[a];
            eb = (issue_en_c && issue_rd_c == a) ? 1'b1 : (m_hit[a] ? 1'b0 : m_pend[a]);
          end
          expect_rd(2, p, ed, eb, "soak");
        end
        for (int r = 0; r < 16; r++) begin
          if (m_hit[r]) begin m_regs[r] = m_val[r]; m_pend[r] = 1'b0; end
        end
        if (issue_en_c && issue_rd_c != 4'h0) m_pend[issue_rd_c] = 1'b1;
        @(negedge clock);
      end
    end
    wr_en_c = 2'b00; issue_en_c = 1'b0;

    @(negedge clock);
    @(negedge clock);
    total_cnt = total_cnt + 1;
    if (exp_q.size() == 0) pass_cnt = pass_cnt + 1;
    else $display("FAIL drain: %0d expectations left unchecked, expected 0", exp_q.size());

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
